tcdm_bank_req_adapter: RTL
==========================

// Module: tcdm_bank_req_adapter
// PURPOSE
//  Per-bank front-end directly upstream of a TCDM SRAM bank, one instance per bank on the
//  interconnect side. The bank has a fixed 1-cycle read latency, no response valid, and may deassert gnt.
//  Converts the interconnect req/gnt + r_valid/r_ready protocol into the bank's strobe interface.
//  Buffers responses in a credit-guarded FIFO so back-pressure on r_ready never loses bank read data.
// PARAMETERS
//  BANK_SIZE   256  words per bank; bank address width AW = $clog2(BANK_SIZE)
//  DATA_WIDTH  32   data width; BE_WIDTH = DATA_WIDTH/8
//  RSP_DEPTH   2    response FIFO entries (>=1); max outstanding = RSP_DEPTH
// PORTS
//  clk_i        in   1         clock
//  rst_ni       in   1         asynchronous active-low reset
//  req_i        in   1         interconnect request
//  wen_i        in   1         1=read, 0=write (bank polarity)
//  add_i        in   AW        word address within bank
//  wdata_i      in   DATA_W    write data
//  be_i         in   BE_W      byte enables
//  gnt_o        out  1         request accepted this cycle
//  r_valid_o    out  1         response valid
//  r_ready_i    in   1         response consumer ready
//  r_rdata_o    out  DATA_W    read data ('0 for write responses)
//  r_opc_o      out  1         wen of the request answered
//  bank_req_o   out  1         to bank: req
//  bank_wen_o / bank_add_o / bank_wdata_o / bank_be_o   out   to bank, pass-through of inputs
//  bank_rdata_i in   DATA_W    bank read data, valid cycle after accepted read
//  bank_gnt_i   in   1         bank grant (tied 1 for non-ECC banks)
// BEHAVIOUR
//  - Reset: gnt_o=0, r_valid_o=0, r_rdata_o='0, r_opc_o=0, bank_req_o=0; FIFO empty, inflight=0.
//  - free = RSP_DEPTH - fifo_cnt - inflight + (r_valid_o & r_ready_i) (pop frees the slot same cycle).
//  - gnt_o = req_i & bank_gnt_i & (free>0); bank_req_o = gnt_o (no bank access without a credit).
//  - Accept at cycle T: inflight<=1, inflight_opc<=wen_i. At T+1 response = {wen?bank_rdata_i:'0, opc}.
//  - Fall-through: at T+1 with FIFO empty, r_valid_o=1 directly from response; 1-cycle latency.
//    Response not taken (r_ready_i=0) or FIFO non-empty -> pushed to FIFO tail, in order.
//  - r_valid_o = inflight | fifo_cnt>0; head = FIFO head if non-empty else inflight response.
//  - Simultaneous push+pop with FIFO full-1 legal; overflow impossible by credit; assert !push|!full.
//  - Back-to-back accepts every cycle sustained when r_ready_i=1 and RSP_DEPTH>=1.
//  - bank_gnt_i=0: gnt_o=0, bank_req_o=0, request held by master; in-flight response unaffected.
//  - Reset mid-op: all state cleared asynchronously; in-flight/buffered responses dropped.
//  - Bank pass-through signals combinational; bank_wdata_o/be_o meaningful only when bank_req_o.
// CONFIGURATION
//  Macro TCDM_BANK_ADAPTER_PERF_EN: adds ports clr_perf_i(in,1), perf_stall_o, perf_rd_o,
//  perf_wr_o (out,32): stall = cycles req_i&!gnt_o; rd/wr = accepted reads/writes; saturating
//  at 2^32-1, cleared by reset or clr_perf_i (clear wins over increment same cycle).
//  Without macro: ports and counters absent; no other behaviour change.
// STRUCTURE
//  Package tcdm_adapter_pkg: rsp_t struct {rdata[DATA_W], opc}, default widths, counter width.
//  Sub-module tcdm_rsp_fifo: parameterised fall-through FIFO of rsp_t (push/pop/full/empty/cnt).
//  Top holds credit logic, inflight register, optional perf counters.
// TESTING
//  1 Read add=0x10 after write 0xDEADBEEF be=4'hF, r_ready=1 -> gnt same cycle, r_valid T+1, rdata=0xDEADBEEF.
//  2 Reads to 0..3 back-to-back, r_ready=0 -> 2 grants (RSP_DEPTH=2), gnt_o=0 after; release -> data in order.
//  3 bank_gnt_i=0 for 3 cycles with req_i=1 -> gnt_o=0, bank_req_o=0; perf_stall_o=3 with PERF_EN.
//  4 Write be=4'b0011 0x12345678 over 0xFFFFFFFF, read back -> 0xFFFF5678; write rsp rdata=0, opc=0.
//  5 Full FIFO + pop and new accept same cycle -> no loss, order preserved, cnt stays RSP_DEPTH.
//  6 rst_ni low with 2 buffered rsps -> r_valid_o=0 immediately; next read after release answers normally.

Source files
------------

// File: rtl/tcdm_adapter_pkg.sv
// Shared types and defaults for the TCDM bank request adapter.
// rsp_t is the default response layout {rdata, opc} at the default data width.
// perf_sat_inc is the saturating increment used by the optional perf counters.
package tcdm_adapter_pkg;

    localparam int unsigned DEF_BANK_SIZE  = 256;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_RSP_DEPTH  = 2;
    localparam int unsigned PERF_CNT_W     = 32;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] rdata;
        logic                      opc;
    } rsp_t;

    // Increment, holding at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_W-1:0] perf_sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tcdm_rsp_fifo.sv
// Fall-through response FIFO: head entry visible on data_o whenever not empty.
// Element type is a type parameter so the top can size it to its data width.
module tcdm_rsp_fifo #(
    parameter int unsigned DEPTH = tcdm_adapter_pkg::DEF_RSP_DEPTH,
    parameter type         rsp_t = tcdm_adapter_pkg::rsp_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  rsp_t             data_i,
    input  logic             pop_i,
    output rsp_t             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!push_i && pop_i) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage write.
    // NOTE: the data array is not reset; empty/cnt guard it, and leaving it reset-free keeps it a plain RAM.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/tcdm_bank_req_adapter.sv
// Per-bank front-end between the interconnect req/gnt + r_valid/r_ready protocol
// and a 1-cycle-latency TCDM SRAM bank. A request is only granted when a response
// slot is guaranteed, so r_ready back-pressure never loses bank read data.
// Optional macro TCDM_BANK_ADAPTER_PERF_EN adds clr_perf_i and the stall/read/write
// performance counters; without it the block has no counters and no extra ports.
module tcdm_bank_req_adapter
    import tcdm_adapter_pkg::*;
#(
    parameter int unsigned BANK_SIZE  = DEF_BANK_SIZE,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = DEF_RSP_DEPTH,
    localparam int unsigned AW        = $clog2(BANK_SIZE),
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  wen_i,
    input  logic [AW-1:0]         add_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_opc_o,
    output logic                  bank_req_o,
    output logic                  bank_wen_o,
    output logic [AW-1:0]         bank_add_o,
    output logic [DATA_WIDTH-1:0] bank_wdata_o,
    output logic [BE_WIDTH-1:0]   bank_be_o,
    input  logic [DATA_WIDTH-1:0] bank_rdata_i,
    input  logic                  bank_gnt_i
`ifdef TCDM_BANK_ADAPTER_PERF_EN
    ,
    input  logic                  clr_perf_i,
    output logic [PERF_CNT_W-1:0] perf_stall_o,
    output logic [PERF_CNT_W-1:0] perf_rd_o,
    output logic [PERF_CNT_W-1:0] perf_wr_o
`endif
);

    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
    // Holds up to RSP_DEPTH + 1 (credit limit while a pop is in progress).
    localparam int unsigned CRED_W = $clog2(RSP_DEPTH + 2);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  opc;
    } bank_rsp_t;

    logic             inflight_q;
    logic             inflight_opc_q;
    bank_rsp_t        rsp_bank;
    bank_rsp_t        rsp_head;
    bank_rsp_t        fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic             rsp_hs;
    logic [CRED_W-1:0] credit_used;
    logic [CRED_W-1:0] credit_limit;
    logic             has_credit;

    // Response of the access accepted last cycle; writes answer with zero data.
    assign rsp_bank.rdata = (inflight_q && inflight_opc_q) ? bank_rdata_i : '0;
    assign rsp_bank.opc   = inflight_q & inflight_opc_q;

    // Older buffered responses always go first; otherwise the bank response falls through.
    assign rsp_head  = fifo_empty ? rsp_bank : fifo_head;
    assign r_valid_o = inflight_q | ~fifo_empty;
    assign r_rdata_o = rsp_head.rdata;
    assign r_opc_o   = rsp_head.opc;
    assign rsp_hs    = r_valid_o & r_ready_i;

    // FIFO control: buffer the bank response unless it leaves directly this cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (rsp_hs && !fifo_empty) fifo_pop = 1'b1;
        if (inflight_q && !(fifo_empty && r_ready_i)) fifo_push = 1'b1;
    end

    // Credit: slots held by buffered + in-flight responses; a pop frees its slot this cycle.
    assign credit_used  = CRED_W'(fifo_cnt) + CRED_W'(inflight_q);
    assign credit_limit = CRED_W'(RSP_DEPTH) + CRED_W'(rsp_hs);
    assign has_credit   = (credit_used < credit_limit);

    assign gnt_o        = req_i & bank_gnt_i & has_credit;
    assign bank_req_o   = gnt_o;
    assign bank_wen_o   = wen_i;
    assign bank_add_o   = add_i;
    assign bank_wdata_o = wdata_i;
    assign bank_be_o    = be_i;

    // Track the access whose data the bank returns next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q     <= 1'b0;
            inflight_opc_q <= 1'b0;
        end else begin
            inflight_q <= gnt_o;
            if (gnt_o) inflight_opc_q <= wen_i;
        end
    end

    tcdm_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .rsp_t (bank_rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (rsp_bank),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

    // The credit scheme must make a push into a full FIFO impossible.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full));

`ifdef TCDM_BANK_ADAPTER_PERF_EN
    logic [PERF_CNT_W-1:0] stall_q;
    logic [PERF_CNT_W-1:0] rd_q;
    logic [PERF_CNT_W-1:0] wr_q;

    // Saturating event counters; clear has priority over counting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else if (clr_perf_i) begin
            stall_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            if (req_i && !gnt_o)  stall_q <= perf_sat_inc(stall_q);
            if (gnt_o && wen_i)   rd_q    <= perf_sat_inc(rd_q);
            if (gnt_o && !wen_i)  wr_q    <= perf_sat_inc(wr_q);
        end
    end

    assign perf_stall_o = stall_q;
    assign perf_rd_o    = rd_q;
    assign perf_wr_o    = wr_q;
`endif

endmodule
